// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally block: FSM state encoding and
// the one-hot vote decoder.
package vote_pkg;

    localparam int unsigned NUM_CAND_DEF = 4;
    localparam int unsigned CNT_W_DEF    = 8;
    localparam int unsigned MAX_CAND     = 8;

    typedef enum logic [1:0] {
        StLocked,
        StArmed,
        StCommit,
        StResult
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] index;
    } onehot_t;

    // valid is set only when exactly one bit of vec is high
    function automatic onehot_t onehot_check(input logic [MAX_CAND-1:0] vec);
        onehot_t     r;
        int unsigned n;
        r = '0;
        n = 0;
        for (int i = 0; i < MAX_CAND; i++) begin
            if (vec[i]) begin
                n       = n + 1;
                r.index = 3'(i);
            end
        end
        r.valid = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones maximum instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    logic [CNT_W-1:0] count_q;

    assign count  = count_q;
    assign at_max = &count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc && !at_max) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vote_tally.sv
// One-vote-per-ballot tally: ballot FSM, per-candidate saturating counters and a
// registered result/leader view.
module vote_tally
    import vote_pkg::*;
#(
    parameter int unsigned NUM_CAND = NUM_CAND_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                ballot_en,
    input  logic [NUM_CAND-1:0] valid_vote,
    input  logic [SEL_W-1:0]    result_sel,
    output logic                ready,
    output logic                vote_ack,
    output logic                vote_err,
    output logic [CNT_W-1:0]    result_count,
    output logic [SEL_W-1:0]    leader,
    output logic                tie,
    output logic                sat
);

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic               vote_err_q;
    logic [CNT_W-1:0]   result_count_q;
    logic [SEL_W-1:0]   leader_q;
    logic               tie_q;
    logic               sat_q;

    logic [MAX_CAND-1:0] vote_ext;
    onehot_t             oh;
    logic                multi;
    logic                commit_now;
    logic [NUM_CAND-1:0] inc;
    logic [NUM_CAND-1:0] at_max;
    logic [CNT_W-1:0]    cnt [NUM_CAND];

    logic [CNT_W-1:0]    max_cnt;
    logic [SEL_W-1:0]    lead_d;
    logic [3:0]          n_max;
    logic                tie_d;
    logic [CNT_W-1:0]    sel_cnt;

    assign vote_ext = MAX_CAND'(valid_vote);
    assign oh       = onehot_check(vote_ext);
    assign multi    = (|valid_vote) && !oh.valid;

    // A pending commit is dropped if result mode is requested in the same cycle
    assign commit_now = (state_q == StCommit) && !mode;

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_cnt
        assign inc[g] = commit_now && (idx_q == 3'(g));
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc    (inc[g]),
            .count  (cnt[g]),
            .at_max (at_max[g])
        );
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (mode) begin
            state_d = StResult;
        end else begin
            case (state_q)
                StLocked: if (ballot_en) state_d = StArmed;
                StArmed: begin
                    if (oh.valid) begin
                        state_d = StCommit;
                        idx_d   = oh.index;
                    end
                end
                StCommit: state_d = StLocked;
                StResult: state_d = StLocked;
                default:  state_d = StLocked;
            endcase
        end
    end

    always_comb begin
        max_cnt = cnt[0];
        lead_d  = '0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (cnt[i] > max_cnt) begin
                max_cnt = cnt[i];
                lead_d  = SEL_W'(i);
            end
        end
        n_max = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (cnt[i] == max_cnt) n_max = n_max + 4'd1;
        end
        tie_d   = (n_max >= 4'd2);
        sel_cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (result_sel == SEL_W'(i)) sel_cnt = cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StLocked;
            idx_q          <= '0;
            vote_err_q     <= 1'b0;
            result_count_q <= '0;
            leader_q       <= '0;
            tie_q          <= 1'b1;
            sat_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            vote_err_q     <= (state_q == StArmed) && !mode && multi;
            result_count_q <= mode ? sel_cnt : '0;
            leader_q       <= lead_d;
            tie_q          <= tie_d;
            sat_q          <= sat_q | (|at_max);
        end
    end

    assign ready        = (state_q == StArmed);
    assign vote_ack     = commit_now;
    assign vote_err     = vote_err_q;
    assign result_count = result_count_q;
    assign leader       = leader_q;
    assign tie          = tie_q;
    assign sat          = sat_q;

endmodule

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally with 3-bit counters so saturation is reachable.
module tb_vote_tally;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       ballot_en;
    logic [3:0] valid_vote;
    logic [1:0] result_sel;
    logic       ready;
    logic       vote_ack;
    logic       vote_err;
    logic [2:0] result_count;
    logic [1:0] leader;
    logic       tie;
    logic       sat;

    int n_checks = 0;
    int n_fail   = 0;

    vote_tally #(
        .NUM_CAND (4),
        .CNT_W    (3),
        .SEL_W    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .ballot_en    (ballot_en),
        .valid_vote   (valid_vote),
        .result_sel   (result_sel),
        .ready        (ready),
        .vote_ack     (vote_ack),
        .vote_err     (vote_err),
        .result_count (result_count),
        .leader       (leader),
        .tie          (tie),
        .sat          (sat)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
    endtask

    task automatic cast(input int c, output logic ack);
        ballot_en  = 1'b1;
        cycle();
        ballot_en  = 1'b0;
        valid_vote = 4'b0001 << c;
        cycle();
        valid_vote = 4'b0000;
        ack        = vote_ack;
        cycle();
    endtask

    task automatic read_count(input int c, output logic [2:0] v);
        mode       = 1'b1;
        result_sel = 2'(c);
        cycle();
        v    = result_count;
        mode = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_checks++;
        if ({ready, vote_ack, vote_err, result_count, leader, tie, sat} !== 10'b0000000010) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required %b",
                     {ready, vote_ack, vote_err, result_count, leader, tie, sat}, 10'b0000000010);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        cycle();
    endtask

    task automatic test_first_vote();
        logic [2:0] v;
        ballot_en = 1'b1;
        cycle();
        ballot_en = 1'b0;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL armed_ready: got %b required 1", ready);
        end
        valid_vote = 4'b0010;
        cycle();
        valid_vote = 4'b0000;
        n_checks++;
        if (vote_ack !== 1'b1 || ready !== 1'b0) begin
            n_fail++; $display("FAIL commit_ack_ready: got ack=%b ready=%b required ack=1 ready=0",
                               vote_ack, ready);
        end
        cycle();
        n_checks++;
        if (vote_ack !== 1'b0) begin
            n_fail++; $display("FAIL ack_one_cycle: got %b required 0", vote_ack);
        end
        cycle();
        n_checks++;
        if (leader !== 2'd1 || tie !== 1'b0) begin
            n_fail++; $display("FAIL first_leader: got leader=%0d tie=%b required leader=1 tie=0",
                               leader, tie);
        end
        read_count(1, v);
        n_checks++;
        if (v !== 3'd1) begin
            n_fail++; $display("FAIL count1_after_vote: got %0d required 1", v);
        end
    endtask

    task automatic test_locked_ignore();
        logic [2:0] v;
        valid_vote = 4'b0100;
        cycle();
        valid_vote = 4'b0000;
        n_checks++;
        if (vote_ack !== 1'b0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL locked_no_ack: got ack=%b ready=%b required 0 0", vote_ack, ready);
        end
        cycle();
        read_count(2, v);
        n_checks++;
        if (v !== 3'd0) begin
            n_fail++; $display("FAIL locked_count2: got %0d required 0", v);
        end
    endtask

    task automatic test_multi_vote();
        logic [2:0] v;
        ballot_en  = 1'b1;
        valid_vote = 4'b0000;
        cycle();
        ballot_en  = 1'b0;
        valid_vote = 4'b0011;
        cycle();
        valid_vote = 4'b0000;
        n_checks++;
        if (vote_err !== 1'b1 || ready !== 1'b1 || vote_ack !== 1'b0) begin
            n_fail++; $display("FAIL multi_err: got err=%b ready=%b ack=%b required 1 1 0",
                               vote_err, ready, vote_ack);
        end
        valid_vote = 4'b0001;
        cycle();
        valid_vote = 4'b0000;
        n_checks++;
        if (vote_ack !== 1'b1 || vote_err !== 1'b0) begin
            n_fail++; $display("FAIL retry_ack: got ack=%b err=%b required 1 0", vote_ack, vote_err);
        end
        cycle();
        read_count(0, v);
        n_checks++;
        if (v !== 3'd1) begin
            n_fail++; $display("FAIL count0_after_retry: got %0d required 1", v);
        end
        read_count(1, v);
        n_checks++;
        if (v !== 3'd1) begin
            n_fail++; $display("FAIL count1_unchanged: got %0d required 1", v);
        end
    endtask

    task automatic test_mode_preempt();
        logic [2:0] v;
        ballot_en = 1'b1;
        cycle();
        ballot_en  = 1'b0;
        valid_vote = 4'b1000;
        mode       = 1'b1;
        result_sel = 2'd3;
        cycle();
        valid_vote = 4'b0000;
        n_checks++;
        if (vote_ack !== 1'b0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL preempt_no_ack: got ack=%b ready=%b required 0 0", vote_ack, ready);
        end
        cycle();
        n_checks++;
        if (result_count !== 3'd0) begin
            n_fail++; $display("FAIL preempt_count3: got %0d required 0", result_count);
        end
        mode = 1'b0;
        cycle();
        n_checks++;
        if (ready !== 1'b0 || result_count !== 3'd0) begin
            n_fail++; $display("FAIL result_exit_locked: got ready=%b count=%0d required 0 0",
                               ready, result_count);
        end
        valid_vote = 4'b1000;
        cycle();
        valid_vote = 4'b0000;
        cycle();
        read_count(3, v);
        n_checks++;
        if (v !== 3'd0) begin
            n_fail++; $display("FAIL rearm_required: got %0d required 0", v);
        end
    endtask

    task automatic test_result_view();
        logic ack;
        do_reset();
        for (int i = 0; i < 3; i++) cast(0, ack);
        for (int i = 0; i < 5; i++) cast(1, ack);
        for (int i = 0; i < 5; i++) cast(2, ack);
        cast(3, ack);
        mode       = 1'b1;
        result_sel = 2'd2;
        cycle();
        n_checks++;
        if (result_count !== 3'd5 || leader !== 2'd1 || tie !== 1'b1) begin
            n_fail++; $display("FAIL result_sel2: got count=%0d leader=%0d tie=%b required 5 1 1",
                               result_count, leader, tie);
        end
        result_sel = 2'd3;
        cycle();
        n_checks++;
        if (result_count !== 3'd1) begin
            n_fail++; $display("FAIL result_sel3: got %0d required 1", result_count);
        end
        result_sel = 2'd0;
        cycle();
        n_checks++;
        if (result_count !== 3'd3) begin
            n_fail++; $display("FAIL result_sel0: got %0d required 3", result_count);
        end
        mode = 1'b0;
        cycle();
        n_checks++;
        if (result_count !== 3'd0) begin
            n_fail++; $display("FAIL result_zero_in_vote: got %0d required 0", result_count);
        end
    endtask

    task automatic test_saturation();
        logic       ack;
        int         acks;
        logic [2:0] v;
        do_reset();
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            cast(2, ack);
            if (ack === 1'b1) acks++;
        end
        cycle();
        n_checks++;
        if (sat !== 1'b0) begin
            n_fail++; $display("FAIL sat_early: got %b required 0", sat);
        end
        for (int i = 0; i < 3; i++) begin
            cast(2, ack);
            if (ack === 1'b1) acks++;
        end
        cycle();
        n_checks++;
        if (acks != 9) begin
            n_fail++; $display("FAIL sat_ack_count: got %0d required 9", acks);
        end
        n_checks++;
        if (sat !== 1'b1 || leader !== 2'd2 || tie !== 1'b0) begin
            n_fail++; $display("FAIL sat_flag: got sat=%b leader=%0d tie=%b required 1 2 0",
                               sat, leader, tie);
        end
        read_count(2, v);
        n_checks++;
        if (v !== 3'd7) begin
            n_fail++; $display("FAIL sat_count2: got %0d required 7", v);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] v;
        ballot_en = 1'b1;
        cycle();
        ballot_en  = 1'b0;
        valid_vote = 4'b0010;
        cycle();
        valid_vote = 4'b0000;
        #1 rst = 1'b0;
        #2;
        n_checks++;
        if (ready !== 1'b0 || vote_ack !== 1'b0 || sat !== 1'b0 || tie !== 1'b1 || leader !== 2'd0) begin
            n_fail++; $display("FAIL async_reset: got ready=%b ack=%b sat=%b tie=%b leader=%0d required 0 0 0 1 0",
                               ready, vote_ack, sat, tie, leader);
        end
        #1 rst = 1'b1;
        cycle();
        read_count(1, v);
        n_checks++;
        if (v !== 3'd0) begin
            n_fail++; $display("FAIL commit_lost: got %0d required 0", v);
        end
        read_count(2, v);
        n_checks++;
        if (v !== 3'd0) begin
            n_fail++; $display("FAIL count2_cleared: got %0d required 0", v);
        end
    endtask

    initial begin
        rst        = 1'b0;
        mode       = 1'b0;
        ballot_en  = 1'b0;
        valid_vote = 4'b0000;
        result_sel = 2'd0;
        test_reset();
        test_first_vote();
        test_locked_ignore();
        test_multi_vote();
        test_mode_preempt();
        test_result_view();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
